// File: rtl/add_acc_lane_wrapp.sv
// add_acc_lane_wrapp
// -------------------
// Multi-lane fixed-point adder / burst accumulator placed after the
// systolic-array drain. Each burst picks one of two modes on its first beat:
//   ADD : LANE_NUM independent A+B additions per beat, one result per beat.
//   ACC : running per-lane sum over a burst closed by add_op_last (or forced
//         out after ACC_MAX_LEN beats). A is used as a bias on the first beat
//         only; later beats add B into the accumulator.
// The side channel (type, last) travels with operand B.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clk_en            global stall, low freezes every register
//   add_mode          0 = ADD, 1 = ACC (taken from the first beat of a burst)
//   add_op_a_word     operand A, lane i at [i*W +: W]
//   add_op_b_word     operand B, lane i at [i*W +: W]
//   add_op_val        beat valid
//   add_op_type       side-channel type of B
//   add_op_last       side-channel last of B, closes an ACC burst
//   add_res_word      result, lane i at [i*W +: W]
//   add_res_val       one-cycle result strobe
//   add_res_type      propagated type
//   add_res_last      propagated last (0 on a forced flush)
//   add_res_satur     per-lane overflow flag, sticky across an ACC burst
//   add_res_cnt       number of beats folded into the result

package add_acc_lane_pkg;

    typedef enum logic [1:0] {
        FIXED_POINT_GENERIC = 2'd0
    } arith_type_e;

    typedef struct packed {
        int unsigned int_wdt;
        int unsigned frac_wdt;
    } fxp_cfg_t;

    typedef struct packed {
        int unsigned word_wdt;
        fxp_cfg_t    fxp_cfg;
        arith_type_e arith_type;
        logic        arith_satur;
    } arith_cfg_t;

    localparam int unsigned C_PIPE_DATA_TYPE_WDT = 3;

endpackage

module add_acc_lane_wrapp
    import add_acc_lane_pkg::*;
#(
    parameter arith_cfg_t ADD_ARITH_CFG = '{word_wdt: 16,
                                            fxp_cfg: '{int_wdt: 8, frac_wdt: 8},
                                            arith_type: FIXED_POINT_GENERIC,
                                            arith_satur: 1'b1},
    parameter int LANE_NUM        = 4,
    parameter int ADD_IN_CYC_LEN  = 1,
    parameter int ADD_OUT_CYC_LEN = 1,
    parameter int ACC_MAX_LEN     = 256,
    localparam int W       = int'(ADD_ARITH_CFG.word_wdt),
    localparam int CNT_WDT = $clog2(ACC_MAX_LEN + 1),
    localparam int TW      = int'(C_PIPE_DATA_TYPE_WDT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  add_mode,
    input  logic [LANE_NUM*W-1:0] add_op_a_word,
    input  logic [LANE_NUM*W-1:0] add_op_b_word,
    input  logic                  add_op_val,
    input  logic [TW-1:0]         add_op_type,
    input  logic                  add_op_last,
    output logic [LANE_NUM*W-1:0] add_res_word,
    output logic                  add_res_val,
    output logic [TW-1:0]         add_res_type,
    output logic                  add_res_last,
    output logic [LANE_NUM-1:0]   add_res_satur,
    output logic [CNT_WDT-1:0]    add_res_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Input register stages
    logic [LANE_NUM*W-1:0] inA_q    [ADD_IN_CYC_LEN];
    logic [LANE_NUM*W-1:0] inB_q    [ADD_IN_CYC_LEN];
    logic                  inVal_q  [ADD_IN_CYC_LEN];
    logic                  inMode_q [ADD_IN_CYC_LEN];
    logic [TW-1:0]         inType_q [ADD_IN_CYC_LEN];
    logic                  inLast_q [ADD_IN_CYC_LEN];

    // Compute-stage view of the oldest input stage
    logic [LANE_NUM*W-1:0] cA;
    logic [LANE_NUM*W-1:0] cB;
    logic                  cVal;
    logic                  cMode;
    logic [TW-1:0]         cType;
    logic                  cLast;

    // Burst state
    state_e                state_q, state_d;
    logic [LANE_NUM*W-1:0] acc_q, acc_d;
    logic [LANE_NUM-1:0]   flag_q, flag_d;
    logic [CNT_WDT-1:0]    cnt_q, cnt_d;

    // Lane adders and emitted result
    logic [W:0]            laneSum;
    logic [LANE_NUM*W-1:0] sumWord;
    logic [LANE_NUM-1:0]   ovf;
    logic [CNT_WDT-1:0]    cntInc;
    logic                  emit;
    logic [LANE_NUM*W-1:0] emitWord;
    logic [LANE_NUM-1:0]   emitFlag;
    logic [CNT_WDT-1:0]    emitCnt;

    // Output stages; index 0 is the compute register
    logic [LANE_NUM*W-1:0] resWord_q [ADD_OUT_CYC_LEN];
    logic                  resVal_q  [ADD_OUT_CYC_LEN];
    logic [TW-1:0]         resType_q [ADD_OUT_CYC_LEN];
    logic                  resLast_q [ADD_OUT_CYC_LEN];
    logic [LANE_NUM-1:0]   resFlag_q [ADD_OUT_CYC_LEN];
    logic [CNT_WDT-1:0]    resCnt_q  [ADD_OUT_CYC_LEN];

    // One lane: sign-extend to W+1 bits, flag when the sum no longer fits
    // in W bits, then clamp or wrap depending on the arithmetic config.
    // Returns {overflow, result}.
    function automatic logic [W:0] addLane(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   sum;
        logic         lovf;
        logic [W-1:0] res;
        sum  = {x[W-1], x} + {y[W-1], y};
        lovf = sum[W] ^ sum[W-1];
        res  = sum[W-1:0];
        if (lovf && ADD_ARITH_CFG.arith_satur) begin
            res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return {lovf, res};
    endfunction

    // Input delay line. Operands and side channel all move together so the
    // compute stage sees a consistent beat; a stall freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ADD_IN_CYC_LEN; s++) begin
                inA_q[s]    <= '0;
                inB_q[s]    <= '0;
                inVal_q[s]  <= 1'b0;
                inMode_q[s] <= 1'b0;
                inType_q[s] <= '0;
                inLast_q[s] <= 1'b0;
            end
        end else if (clk_en) begin
            inA_q[0]    <= add_op_a_word;
            inB_q[0]    <= add_op_b_word;
            inVal_q[0]  <= add_op_val;
            inMode_q[0] <= add_mode;
            inType_q[0] <= add_op_type;
            inLast_q[0] <= add_op_last;
            for (int s = 1; s < ADD_IN_CYC_LEN; s++) begin
                inA_q[s]    <= inA_q[s-1];
                inB_q[s]    <= inB_q[s-1];
                inVal_q[s]  <= inVal_q[s-1];
                inMode_q[s] <= inMode_q[s-1];
                inType_q[s] <= inType_q[s-1];
                inLast_q[s] <= inLast_q[s-1];
            end
        end
    end

    assign cA    = inA_q[ADD_IN_CYC_LEN-1];
    assign cB    = inB_q[ADD_IN_CYC_LEN-1];
    assign cVal  = inVal_q[ADD_IN_CYC_LEN-1];
    assign cMode = inMode_q[ADD_IN_CYC_LEN-1];
    assign cType = inType_q[ADD_IN_CYC_LEN-1];
    assign cLast = inLast_q[ADD_IN_CYC_LEN-1];

    // Lane adders plus the burst FSM. The first operand is A while idle
    // (plain add, or bias on the first accumulation beat) and the stored
    // accumulator while a burst is open. The accumulator keeps the already
    // clamped/wrapped W-bit value, so overflow is judged beat by beat.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        flag_d   = flag_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        laneSum  = '0;
        sumWord  = '0;
        ovf      = '0;
        cntInc   = cnt_q + CNT_WDT'(1);

        for (int l = 0; l < LANE_NUM; l++) begin
            laneSum = addLane((state_q == ST_ACC) ? acc_q[l*W +: W] : cA[l*W +: W],
                              cB[l*W +: W]);
            sumWord[l*W +: W] = laneSum[W-1:0];
            ovf[l]            = laneSum[W];
        end

        emitWord = sumWord;
        emitFlag = ovf;
        emitCnt  = CNT_WDT'(1);

        case (state_q)
            ST_IDLE: begin
                if (cVal) begin
                    if (!cMode) begin
                        emit = 1'b1;
                    end else begin
                        acc_d  = sumWord;
                        flag_d = ovf;
                        cnt_d  = CNT_WDT'(1);
                        if (cLast || (CNT_WDT'(1) == CNT_WDT'(ACC_MAX_LEN))) begin
                            emit = 1'b1;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
            end
            ST_ACC: begin
                if (cVal) begin
                    acc_d    = sumWord;
                    flag_d   = flag_q | ovf;
                    cnt_d    = cntInc;
                    emitFlag = flag_q | ovf;
                    emitCnt  = cntInc;
                    if (cLast || (cntInc == CNT_WDT'(ACC_MAX_LEN))) begin
                        emit    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst state, compute register and the trailing output delay stages.
    // The compute register only loads payload when a result is emitted;
    // the valid bit alone marks it, giving a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            flag_q  <= '0;
            cnt_q   <= '0;
            for (int s = 0; s < ADD_OUT_CYC_LEN; s++) begin
                resWord_q[s] <= '0;
                resVal_q[s]  <= 1'b0;
                resType_q[s] <= '0;
                resLast_q[s] <= 1'b0;
                resFlag_q[s] <= '0;
                resCnt_q[s]  <= '0;
            end
        end else if (clk_en) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
            resVal_q[0] <= emit;
            if (emit) begin
                resWord_q[0] <= emitWord;
                resType_q[0] <= cType;
                resLast_q[0] <= cLast;
                resFlag_q[0] <= emitFlag;
                resCnt_q[0]  <= emitCnt;
            end
            for (int s = 1; s < ADD_OUT_CYC_LEN; s++) begin
                resWord_q[s] <= resWord_q[s-1];
                resVal_q[s]  <= resVal_q[s-1];
                resType_q[s] <= resType_q[s-1];
                resLast_q[s] <= resLast_q[s-1];
                resFlag_q[s] <= resFlag_q[s-1];
                resCnt_q[s]  <= resCnt_q[s-1];
            end
        end
    end

    assign add_res_word  = resWord_q[ADD_OUT_CYC_LEN-1];
    assign add_res_val   = resVal_q[ADD_OUT_CYC_LEN-1];
    assign add_res_type  = resType_q[ADD_OUT_CYC_LEN-1];
    assign add_res_last  = resLast_q[ADD_OUT_CYC_LEN-1];
    assign add_res_satur = resFlag_q[ADD_OUT_CYC_LEN-1];
    assign add_res_cnt   = resCnt_q[ADD_OUT_CYC_LEN-1];

endmodule

// File: tb/tb_add_acc_lane_wrapp.sv
// tb_add_acc_lane_wrapp
// ---------------------
// Two instances share one stimulus stream:
//   S : saturating, ACC_MAX_LEN=4, 1 input + 1 output stage (L=2)
//   W : wrapping,   ACC_MAX_LEN=256, 2 input + 2 output stages (L=4)
// A burst-level behavioural model predicts each instance's outputs and a
// negedge process compares them every cycle; directed sections add literal
// expectations, then a randomized section runs against the model.

module tb_add_acc_lane_wrapp;

    localparam int TW = int'(add_acc_lane_pkg::C_PIPE_DATA_TYPE_WDT);

    logic          clk = 1'b0;
    logic          rst;
    logic          clkEn;
    logic          addMode;
    logic [63:0]   opA;
    logic [63:0]   opB;
    logic          opVal;
    logic [TW-1:0] opType;
    logic          opLast;

    logic [63:0]   wordS, wordW;
    logic          valS, valW;
    logic [TW-1:0] typeS, typeW;
    logic          lastS, lastW;
    logic [3:0]    saturS, saturW;
    logic [2:0]    cntS;
    logic [8:0]    cntW;

    logic [63:0]   dWord  [2];
    logic          dVal   [2];
    logic [TW-1:0] dType  [2];
    logic          dLast  [2];
    logic [3:0]    dSatur [2];
    logic [8:0]    dCnt   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_acc_lane_wrapp #(
        .LANE_NUM(4), .ADD_IN_CYC_LEN(1), .ADD_OUT_CYC_LEN(1), .ACC_MAX_LEN(4)
    ) dutS (
        .clk(clk), .rst(rst), .clk_en(clkEn), .add_mode(addMode),
        .add_op_a_word(opA), .add_op_b_word(opB), .add_op_val(opVal),
        .add_op_type(opType), .add_op_last(opLast),
        .add_res_word(wordS), .add_res_val(valS), .add_res_type(typeS),
        .add_res_last(lastS), .add_res_satur(saturS), .add_res_cnt(cntS)
    );

    add_acc_lane_wrapp #(
        .ADD_ARITH_CFG(add_acc_lane_pkg::arith_cfg_t'{word_wdt: 16,
                                                      fxp_cfg: '{int_wdt: 8, frac_wdt: 8},
                                                      arith_type: add_acc_lane_pkg::FIXED_POINT_GENERIC,
                                                      arith_satur: 1'b0}),
        .LANE_NUM(4), .ADD_IN_CYC_LEN(2), .ADD_OUT_CYC_LEN(2), .ACC_MAX_LEN(256)
    ) dutW (
        .clk(clk), .rst(rst), .clk_en(clkEn), .add_mode(addMode),
        .add_op_a_word(opA), .add_op_b_word(opB), .add_op_val(opVal),
        .add_op_type(opType), .add_op_last(opLast),
        .add_res_word(wordW), .add_res_val(valW), .add_res_type(typeW),
        .add_res_last(lastW), .add_res_satur(saturW), .add_res_cnt(cntW)
    );

    assign dWord[0]  = wordS;          assign dWord[1]  = wordW;
    assign dVal[0]   = valS;           assign dVal[1]   = valW;
    assign dType[0]  = typeS;          assign dType[1]  = typeW;
    assign dLast[0]  = lastS;          assign dLast[1]  = lastW;
    assign dSatur[0] = saturS;         assign dSatur[1] = saturW;
    assign dCnt[0]   = {6'd0, cntS};   assign dCnt[1]   = cntW;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          val;
        logic [63:0]   word;
        logic [3:0]    flag;
        logic [8:0]    cnt;
        logic [TW-1:0] typ;
        logic          last;
    } res_t;

    res_t        mPipe   [2][4];
    res_t        mOut    [2];
    bit          mActive [2];
    int          mCnt    [2];
    logic [63:0] mAcc    [2];
    logic [3:0]  mFlag   [2];
    bit          rstSeen [2];
    bit          started = 1'b0;

    function automatic int pipeDepth(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int maxLen(input int k);
        return (k == 0) ? 4 : 256;
    endfunction

    function automatic string instName(input int k);
        return (k == 0) ? "S" : "W";
    endfunction

    // Signed 16-bit addition done in plain integers.
    task automatic laneAdd(input int k, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] r, output logic o);
        int s;
        s = int'($signed(x)) + int'($signed(y));
        o = (s > 32767) || (s < -32768);
        if (o && (k == 0)) r = (s > 0) ? 16'h7FFF : 16'h8000;
        else               r = s[15:0];
    endtask

    // What one accepted beat produces: a result now, or nothing yet.
    task automatic modelBeat(input int k, output res_t em);
        logic [15:0] r;
        logic        o;
        em = '0;
        if (!opVal) return;
        if (!mActive[k] && !addMode) begin
            em.val  = 1'b1;
            em.cnt  = 9'd1;
            em.typ  = opType;
            em.last = opLast;
            for (int l = 0; l < 4; l++) begin
                laneAdd(k, opA[l*16 +: 16], opB[l*16 +: 16], r, o);
                em.word[l*16 +: 16] = r;
                em.flag[l]          = o;
            end
            return;
        end
        if (!mActive[k]) begin
            mActive[k] = 1'b1;
            mCnt[k]    = 1;
            for (int l = 0; l < 4; l++) begin
                laneAdd(k, opA[l*16 +: 16], opB[l*16 +: 16], r, o);
                mAcc[k][l*16 +: 16] = r;
                mFlag[k][l]         = o;
            end
        end else begin
            mCnt[k] = mCnt[k] + 1;
            for (int l = 0; l < 4; l++) begin
                laneAdd(k, mAcc[k][l*16 +: 16], opB[l*16 +: 16], r, o);
                mAcc[k][l*16 +: 16] = r;
                mFlag[k][l]         = mFlag[k][l] | o;
            end
        end
        if (opLast || (mCnt[k] == maxLen(k))) begin
            em.val     = 1'b1;
            em.word    = mAcc[k];
            em.flag    = mFlag[k];
            em.cnt     = 9'(mCnt[k]);
            em.typ     = opType;
            em.last    = opLast;
            mActive[k] = 1'b0;
        end
    endtask

    // A result shows up L-1 enabled edges after the edge that took its beat.
    always @(posedge clk) begin
        res_t em;
        for (int k = 0; k < 2; k++) begin
            rstSeen[k] = rst;
            if (rst) begin
                mActive[k] = 1'b0;
                mCnt[k]    = 0;
                mAcc[k]    = '0;
                mFlag[k]   = '0;
                mOut[k]    = '0;
                for (int j = 0; j < 4; j++) mPipe[k][j] = '0;
            end else if (clkEn) begin
                modelBeat(k, em);
                mOut[k] = mPipe[k][pipeDepth(k)-1];
                for (int j = pipeDepth(k) - 1; j > 0; j--) mPipe[k][j] = mPipe[k][j-1];
                mPipe[k][0] = em;
            end
        end
        started = 1'b1;
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input int k);
        string n;
        n = instName(k);
        cmp({n, ".val"}, 64'(dVal[k]), 64'(mOut[k].val));
        if (rstSeen[k] || mOut[k].val) begin
            cmp({n, ".word"},  dWord[k],          mOut[k].word);
            cmp({n, ".satur"}, 64'(dSatur[k]),    64'(mOut[k].flag));
            cmp({n, ".cnt"},   64'(dCnt[k]),      64'(mOut[k].cnt));
            cmp({n, ".type"},  64'(dType[k]),     64'(mOut[k].typ));
            cmp({n, ".last"},  64'(dLast[k]),     64'(mOut[k].last));
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput(0);
            checkOutput(1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic mode,
                                 input logic last, input logic [TW-1:0] typ);
        opA     = a;
        opB     = b;
        addMode = mode;
        opLast  = last;
        opType  = typ;
        opVal   = 1'b1;
        @(negedge clk);
        opVal  = 1'b0;
        opLast = 1'b0;
    endtask

    task automatic waitVal(input int k, input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (dVal[k]) return;
        end
        failures++;
        checks++;
        $display("[TB] FAIL %s.timeout got=none exp=result within %0d cycles", instName(k), budget);
    endtask

    int w;

    initial begin
        rst     = 1'b1;
        clkEn   = 1'b0;
        addMode = 1'b0;
        opA     = '0;
        opB     = '0;
        opVal   = 1'b0;
        opType  = '0;
        opLast  = 1'b0;
        repeat (2) @(negedge clk);
        // reset works with clk_en low
        cmp("reset.S.val",  64'(valS),  64'd0);
        cmp("reset.W.word", wordW,      64'd0);
        cmp("reset.W.cnt",  64'(cntW),  64'd0);
        rst   = 1'b0;
        clkEn = 1'b1;
        @(negedge clk);

        // element-wise add: normal lanes plus lane1 overflow
        $display("[TB] element-wise add");
        applyStimulus({16'h0003, 16'h0001, 16'h7F00, 16'h0180},
                      {16'h0004, 16'h0002, 16'h0200, 16'h0240}, 1'b0, 1'b0, 3'd2);
        waitVal(0, 8, w);
        cmp("add.S.latency", 64'(w), 64'd1);
        cmp("add.S.word",  wordS, {16'h0007, 16'h0003, 16'h7FFF, 16'h03C0});
        cmp("add.S.satur", 64'(saturS), 64'b0010);
        cmp("add.S.cnt",   64'(cntS),   64'd1);
        cmp("add.S.type",  64'(typeS),  64'd2);
        waitVal(1, 8, w);
        cmp("add.W.latency", 64'(w), 64'd2);
        cmp("add.W.word",  wordW, {16'h0007, 16'h0003, 16'h8100, 16'h03C0});
        cmp("add.W.satur", 64'(saturW), 64'b0010);

        // three-beat accumulation with bias
        $display("[TB] accumulation burst");
        applyStimulus({4{16'h0100}}, {4{16'h0100}}, 1'b1, 1'b0, 3'd3);
        applyStimulus({4{16'h0100}}, {4{16'h0200}}, 1'b1, 1'b0, 3'd2);
        applyStimulus({4{16'h0100}}, {4{16'h0300}}, 1'b1, 1'b1, 3'd1);
        waitVal(0, 8, w);
        cmp("acc.S.latency", 64'(w), 64'd1);
        cmp("acc.S.word", wordS, {4{16'h0700}});
        cmp("acc.S.cnt",  64'(cntS),  64'd3);
        cmp("acc.S.last", 64'(lastS), 64'd1);
        cmp("acc.S.type", 64'(typeS), 64'd1);
        waitVal(1, 8, w);
        cmp("acc.W.word", wordW, {4{16'h0700}});

        // forced flush on S after 4 beats, W keeps one long burst
        $display("[TB] forced flush");
        for (int i = 0; i < 4; i++) applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        waitVal(0, 8, w);
        cmp("flush.S.word", wordS, {4{16'h0400}});
        cmp("flush.S.cnt",  64'(cntS),  64'd4);
        cmp("flush.S.last", 64'(lastS), 64'd0);
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b1, 3'd0);
        waitVal(0, 8, w);
        cmp("flush2.S.word", wordS, {4{16'h0300}});
        cmp("flush2.S.cnt",  64'(cntS), 64'd3);
        waitVal(1, 8, w);
        cmp("flush.W.word", wordW, {4{16'h0700}});
        cmp("flush.W.cnt",  64'(cntW), 64'd7);

        // stall and bubbles inside a burst
        $display("[TB] stall inside burst");
        applyStimulus({4{16'h0010}}, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        applyStimulus({4{16'h0010}}, {4{16'h0200}}, 1'b1, 1'b0, 3'd0);
        clkEn   = 1'b0;
        opVal   = 1'b1;
        opB     = {4{16'h7777}};
        addMode = 1'b0;
        opLast  = 1'b1;
        repeat (3) @(negedge clk);
        clkEn = 1'b1;
        applyStimulus({4{16'h0010}}, {4{16'h0300}}, 1'b1, 1'b1, 3'd5);
        waitVal(0, 8, w);
        cmp("stall.S.word", wordS, {4{16'h0610}});
        cmp("stall.S.cnt",  64'(cntS), 64'd3);
        waitVal(1, 8, w);
        cmp("stall.W.word", wordW, {4{16'h0610}});

        // stall right after a beat delays the result by the stall length
        applyStimulus({4{16'h0001}}, {4{16'h0002}}, 1'b0, 1'b0, 3'd4);
        clkEn = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                clkEn = 1'b1;
            end
        join_none
        waitVal(0, 12, w);
        cmp("stall.S.latency", 64'(w), 64'd4);
        cmp("stall2.S.word", wordS, {4{16'h0003}});
        waitVal(1, 12, w);
        cmp("stall.W.latency", 64'(w), 64'd2);

        // reset in the middle of a burst drops the partial sum
        $display("[TB] reset mid-burst");
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        rst = 1'b1;
        @(negedge clk);
        cmp("rst.S.word", wordS, 64'd0);
        cmp("rst.S.cnt",  64'(cntS), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b0, 3'd0);
        applyStimulus('0, {4{16'h0100}}, 1'b1, 1'b1, 3'd6);
        waitVal(0, 8, w);
        cmp("rst.S.after.word", wordS, {4{16'h0200}});
        cmp("rst.S.after.cnt",  64'(cntS), 64'd2);
        waitVal(1, 8, w);
        cmp("rst.W.after.cnt",  64'(cntW), 64'd2);

        // randomized traffic against the model
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            clkEn   = ($urandom_range(0, 9) != 0);
            opVal   = ($urandom_range(0, 2) != 0);
            addMode = 1'($urandom_range(0, 1));
            opLast  = ($urandom_range(0, 3) == 0);
            opType  = TW'($urandom);
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 1) == 0) begin
                    opA[l*16 +: 16] = 16'($urandom);
                    opB[l*16 +: 16] = 16'($urandom);
                end else begin
                    opA[l*16 +: 16] = 16'($urandom_range(0, 1023));
                    opB[l*16 +: 16] = 16'($urandom_range(0, 1023));
                end
            end
            @(negedge clk);
        end
        rst   = 1'b0;
        clkEn = 1'b1;
        opVal = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
